// File: rtl/complex_result_collector.sv
// ---------------------------------------------------------------------------
// complex_result_collector
//
// Collects NI-element complex result chunks strobed out of the matrix-by-vector
// engine, buffers them in a small FIFO and writes them to the result vector
// memory at consecutive addresses. Padding lanes of the final chunk are zeroed
// and done is raised once every expected chunk has been written.
//
// Ports:
//   clk            clock
//   reset          synchronous active-high reset (priority over start)
//   start          level enable; low soft-clears back to IDLE
//   in_data        result chunk, element 0 in the MSBs
//   in_valid       one-cycle strobe qualifying in_data
//   total_rows     number of result elements expected (sampled on start rise)
//   base_addr      first write address (sampled on start rise)
//   mem_ready      memory accepts a write this cycle
//   mem_wr_en      write request (FIFO non-empty while running)
//   mem_wr_addr    base_addr + chunks_written, truncated to ADDR_W
//   mem_wr_data    FIFO head (zero when no write is requested)
//   chunks_written chunks committed since start
//   overflow       sticky: a chunk was dropped because the FIFO was full
//   done           all expected chunks have been written
// ---------------------------------------------------------------------------
module complex_result_collector #(
    parameter int element_width = 64,
    parameter int NI            = 8,
    parameter int DEPTH         = 4,
    parameter int ADDR_W        = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NI*element_width-1:0] in_data,
    input  logic                        in_valid,
    input  logic [31:0]                 total_rows,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic                        mem_ready,
    output logic                        mem_wr_en,
    output logic [ADDR_W-1:0]           mem_wr_addr,
    output logic [NI*element_width-1:0] mem_wr_data,
    output logic [31:0]                 chunks_written,
    output logic                        overflow,
    output logic                        done
);

    localparam int CW    = NI * element_width;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state, state_next;
    logic              start_q;
    logic [31:0]       total_q;
    logic [31:0]       expected_q;
    logic [31:0]       accepted_q;
    logic [ADDR_W-1:0] base_q;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]     fifo_mem [DEPTH];

    logic              start_rise;
    logic [31:0]       expected_calc;
    logic [31:0]       last_rem;
    logic              fifo_full, fifo_empty;
    logic              room_left;
    logic              last_chunk;
    logic              push, pop, drop_full;
    logic [CW-1:0]     push_data;

    // Ceiling division done as quotient plus "remainder non-zero" so it cannot
    // overflow 32 bits even for total_rows near 2^32.
    assign expected_calc = (total_rows / 32'(NI)) + {31'd0, |(total_rows % 32'(NI))};
    assign start_rise    = start & ~start_q;

    // The extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                        (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);

    assign mem_wr_en   = (state == S_RUN) && !fifo_empty;
    assign mem_wr_data = mem_wr_en ? fifo_mem[rd_ptr[IDX_W-1:0]] : '0;
    assign mem_wr_addr = base_q + chunks_written[ADDR_W-1:0];
    assign done        = (state == S_DONE);

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    // Chunks beyond the expected count are silently ignored and never flag.
    assign pop        = mem_wr_en && mem_ready;
    assign room_left  = (accepted_q < expected_q);
    assign push       = (state == S_RUN) && in_valid && room_left && (!fifo_full || pop);
    assign drop_full  = (state == S_RUN) && in_valid && room_left && fifo_full && !pop;
    assign last_chunk = (accepted_q == expected_q - 32'd1);
    assign last_rem   = total_q % 32'(NI);

    // Zero the padding lanes of the final chunk. Only a partial final chunk
    // (non-zero remainder) has padding; lanes at or beyond the remainder are
    // past total_rows. Lane 0 sits in the MSBs.
    always_comb begin
        push_data = in_data;
        if (last_chunk && (last_rem != 32'd0)) begin
            for (int k = 0; k < NI; k++) begin
                if (32'(k) >= last_rem) begin
                    push_data[(NI-1-k)*element_width +: element_width] = '0;
                end
            end
        end
    end

    // State register. Dropping start acts like a soft reset back to IDLE.
    always_ff @(posedge clk) begin
        if (reset || !start) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A zero-length job skips RUN entirely. RUN ends on the
    // commit of the last expected chunk so done appears the following cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_rise) begin
                    state_next = (expected_calc == 32'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (pop && (chunks_written + 32'd1 == expected_q)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_DONE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Job bookkeeping and FIFO pointers. Everything returns to its reset value
    // when start is low, which also discards any pending writes.
    always_ff @(posedge clk) begin
        if (reset || !start) begin
            start_q        <= 1'b0;
            total_q        <= '0;
            expected_q     <= '0;
            accepted_q     <= '0;
            base_q         <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            chunks_written <= '0;
            overflow       <= 1'b0;
        end else begin
            start_q <= start;
            if ((state == S_IDLE) && start_rise) begin
                total_q    <= total_rows;
                base_q     <= base_addr;
                expected_q <= expected_calc;
                accepted_q <= '0;
            end
            if (push) begin
                wr_ptr     <= wr_ptr + PTR_W'(1);
                accepted_q <= accepted_q + 32'd1;
            end
            if (pop) begin
                rd_ptr         <= rd_ptr + PTR_W'(1);
                chunks_written <= chunks_written + 32'd1;
            end
            if (drop_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage is not cleared by reset or start; the pointers alone
    // decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: doc/complex_result_collector.md
Name: complex_result_collector

Overview:
- Downstream consumer of the complex matrix-by-vector engine's decoder output.
- Captures each NI-element result chunk when the engine pulses its read strobe, and buffers chunks in a small FIFO.
- Drains chunks into the result vector memory, one write per chunk at consecutive addresses, honouring memory backpressure.
- Zero-fills padding lanes of the final chunk and raises done once every expected chunk is written, so the solver controller can start the next phase.

Parameters:
- element_width, 64, bits per complex element (32-bit real in upper half, 32-bit imaginary in lower half)
- NI, 8, elements per chunk
- DEPTH, 4, FIFO depth in chunks (power of two, >=2)
- ADDR_W, 16, result memory address width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- start  input  1  level enable; low = soft clear to IDLE
- in_data  input  NI*element_width  result chunk from engine; element 0 in MSBs
- in_valid  input  1  one-cycle strobe: in_data valid this cycle
- total_rows  input  32  result elements expected; sampled when start rises
- base_addr  input  ADDR_W  first write address; sampled when start rises
- mem_ready  input  1  memory accepts a write this cycle
- mem_wr_en  output  1  write request
- mem_wr_addr  output  ADDR_W  write address
- mem_wr_data  output  NI*element_width  write data
- chunks_written  output  32  chunks committed since start
- overflow  output  1  sticky: a chunk was dropped
- done  output  1  all expected chunks written

Behaviour:
- Reset values: mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, chunks_written=0, overflow=0, done=0, FIFO empty, state IDLE.
- !start (when not in reset) gives the same values as reset, except the FIFO storage contents are not cleared. Reset has priority over start.
- expected_chunks = ceil(total_rows/NI), computed with 32-bit arithmetic at start rise and held internally.
- State IDLE:
  - On start rising edge: latch total_rows, base_addr and expected_chunks; clear accepted_count; go to RUN.
  - If expected_chunks==0, go to DONE instead.
- State RUN:
  - Accept: in_valid & FIFO not full & accepted_count<expected_chunks pushes in_data and increments accepted_count.
  - Final-chunk masking: on the chunk where accepted_count==expected_chunks-1, lanes k with (expected_chunks-1)*NI+k >= total_rows are replaced by 64'd0 before the push.
  - Drop case 1: in_valid while FIFO is full drops the chunk and sets overflow (sticky until reset or !start). accepted_count is unchanged.
  - Drop case 2: in_valid once accepted_count==expected_chunks ignores the chunk, with no flag.
  - Drain: mem_wr_en is asserted whenever the FIFO is non-empty. mem_wr_data is the FIFO head; mem_wr_addr = latched base_addr + chunks_written, truncated to ADDR_W.
  - A write commits on a cycle with mem_wr_en & mem_ready. On commit: pop the FIFO and increment chunks_written. If mem_ready=0, the head, address and mem_wr_en hold stable.
  - Simultaneous push and pop on a full FIFO: the pop frees a slot and the push is accepted with no overflow. A push on an empty FIFO is not visible to the pop until the next cycle.
  - Latency: a chunk accepted in cycle N gives mem_wr_en=1 at cycle N+1 at the earliest. Sustained throughput is 1 chunk/cycle with mem_ready=1.
  - Go to DONE in the cycle after the commit that makes chunks_written==expected_chunks.
- State DONE:
  - done=1, mem_wr_en=0; in_valid is ignored.
  - Stays in DONE while start is high. start low returns to IDLE with done=0 on the next edge.
- FIFO: read and write pointers are log2(DEPTH)+1 bits wide, with wrap-around via the extra MSB. full = MSBs differ and the rest is equal; empty = pointers equal.
- start dropping mid-RUN abandons the operation: FIFO pointers clear, pending writes are discarded, mem_wr_en=0 next cycle.

Test Plan:
- Basic: NI=8, total_rows=16, base_addr=0x100, mem_ready=1, two in_valid pulses 3 cycles apart -> writes at 0x100 then 0x101, each one cycle after its strobe, data intact; done=1 one cycle after the second write; chunks_written=2.
- Padding: total_rows=13 -> expected_chunks=2; second chunk lanes 5..7 written as 0, lanes 0..4 unchanged.
- Backpressure/overflow: DEPTH=4, mem_ready=0, 5 back-to-back in_valid with total_rows=64 -> first 4 held and mem_wr_en=1 with address base_addr stable; 5th dropped with overflow=1. Then mem_ready=1 -> 4 writes in consecutive cycles; done stays 0 since 4<8.
- Full with simultaneous pop: FIFO full and mem_ready=1, in_valid=1 -> chunk accepted, overflow stays 0, occupancy stays 4.
- Zero rows and excess: total_rows=0 -> done one cycle after start rises, no writes. total_rows=8 with 3 strobes -> exactly 1 write and done=1; extra chunks ignored, overflow=0.
- Abort/reset: drop start after 1 of 2 chunks is accepted with mem_ready=0 -> mem_wr_en=0 and chunks_written=0 next cycle; re-raise start -> fresh run from base_addr. Assert reset mid-RUN -> all outputs at reset values next cycle.
